// File: rtl/tdc_spi_pkg.sv
// Shared types and constants for the TDC SPI responder: FSM states, command byte layout
// and default widths.
package tdc_spi_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    RD,
    WR
  } state_t;

  localparam int unsigned CMD_AI_BIT = 7;
  localparam int unsigned CMD_RW_BIT = 6;
  localparam int unsigned CMD_WIDTH  = 8;

  localparam int unsigned DEF_ADDR_WIDTH  = 6;
  localparam int unsigned DEF_RD_WIDTH    = 24;
  localparam int unsigned DEF_WR_WIDTH    = 8;
  localparam int unsigned DEF_SYNC_STAGES = 2;

  function automatic int unsigned max3(int unsigned a, int unsigned b, int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/tdc_spi_responder_if.sv
// Register-file port of the SPI responder: read request/data and write strobe.
interface tdc_spi_responder_if
  import tdc_spi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned RD_WIDTH   = DEF_RD_WIDTH,
  parameter int unsigned WR_WIDTH   = DEF_WR_WIDTH
) ();

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [RD_WIDTH-1:0]   rd_data;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [WR_WIDTH-1:0]   wr_data;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    output wr_en,
    output wr_addr,
    output wr_data
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

endinterface

// File: rtl/spi_sync_edge.sv
// Multi-flop synchronizer for an asynchronous pin with registered one-clk rise/fall pulses.
// Flops reset low so a pin already low at reset release produces no falling edge.
module spi_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise_q;
  logic                   fall_q;

  assign level = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= (sync_q << 1) | SYNC_STAGES'(d);
      prev_q <= level;
      rise_q <= level & ~prev_q;
      fall_q <= ~level & prev_q;
    end
  end

  assign rise = rise_q;
  assign fall = fall_q;

endmodule

// File: rtl/tdc_spi_responder.sv
// SPI mode-0 slave for the TDC command/data protocol: decodes the command byte and turns
// each frame into register-port read requests and write strobes.
module tdc_spi_responder
  import tdc_spi_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
  parameter int unsigned RD_WIDTH    = DEF_RD_WIDTH,
  parameter int unsigned WR_WIDTH    = DEF_WR_WIDTH,
  parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                sclk,
  input  logic                ss_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  output logic                frame_done,
  output logic                busy,
  tdc_spi_responder_if.master reg_port
);

  localparam int unsigned MAX_WIDTH = max3(CMD_WIDTH, RD_WIDTH, WR_WIDTH);
  localparam int unsigned CNT_WIDTH = $clog2(MAX_WIDTH);

  logic sclk_level, sclk_rise, sclk_fall;
  logic ss_level, ss_rise, ss_fall;
  logic unused_sclk_level;
  logic [SYNC_STAGES-1:0] mosi_sync_q;
  logic mosi_s;

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sclk_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (sclk),
    .level(sclk_level),
    .rise (sclk_rise),
    .fall (sclk_fall)
  );

  spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ss_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d    (ss_n),
    .level(ss_level),
    .rise (ss_rise),
    .fall (ss_fall)
  );

  assign unused_sclk_level = sclk_level;
  assign mosi_s            = mosi_sync_q[SYNC_STAGES-1];

  state_t                state_q, state_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CMD_WIDTH-2:0]  cmd_q, cmd_d;
  logic [WR_WIDTH-2:0]   rx_q, rx_d;
  logic [RD_WIDTH-1:0]   tx_q, tx_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  ai_q, ai_d;
  logic                  done_q, done_d;
  logic                  miso_q, miso_d;
  logic                  rd_en_q, rd_en_d;
  logic                  load_q, load_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [WR_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                  frame_done_q, frame_done_d;

  logic [CMD_WIDTH-1:0]  cmd_word;
  logic [WR_WIDTH-1:0]   wr_word;

  assign cmd_word = {cmd_q, mosi_s};
  assign wr_word  = {rx_q, mosi_s};

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    cmd_d        = cmd_q;
    rx_d         = rx_q;
    tx_d         = tx_q;
    addr_d       = addr_q;
    ai_d         = ai_q;
    done_d       = done_q;
    miso_d       = miso_q;
    rd_en_d      = 1'b0;
    load_d       = rd_en_q;
    rd_addr_d    = rd_addr_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    frame_done_d = 1'b0;

    // A deasserting select overrides any SCLK edge seen in the same cycle.
    if (ss_rise) begin
      frame_done_d = (state_q != IDLE);
      state_d      = IDLE;
      cnt_d        = '0;
      done_d       = 1'b0;
      miso_d       = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          miso_d = 1'b0;
          if (ss_fall) begin
            state_d = CMD;
            cnt_d   = '0;
            done_d  = 1'b0;
          end
        end
        CMD: begin
          miso_d = 1'b0;
          if (sclk_rise) begin
            cmd_d = cmd_word[CMD_WIDTH-2:0];
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(CMD_WIDTH - 1)) begin
              cnt_d  = '0;
              ai_d   = cmd_word[CMD_AI_BIT];
              addr_d = cmd_word[ADDR_WIDTH-1:0];
              if (cmd_word[CMD_RW_BIT]) begin
                state_d = WR;
              end else begin
                state_d   = RD;
                rd_en_d   = 1'b1;
                rd_addr_d = cmd_word[ADDR_WIDTH-1:0];
              end
            end
          end
        end
        RD: begin
          if (done_q) begin
            miso_d = 1'b0;
          end else if (sclk_fall) begin
            miso_d = tx_q[RD_WIDTH-1];
            tx_d   = {tx_q[RD_WIDTH-2:0], 1'b0};
          end
          if (sclk_rise && !done_q) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(RD_WIDTH - 1)) begin
              cnt_d = '0;
              if (ai_q) begin
                addr_d    = addr_q + ADDR_WIDTH'(1);
                rd_en_d   = 1'b1;
                rd_addr_d = addr_q + ADDR_WIDTH'(1);
              end else begin
                done_d = 1'b1;
              end
            end
          end
        end
        WR: begin
          miso_d = 1'b0;
          if (sclk_rise && !done_q) begin
            rx_d  = wr_word[WR_WIDTH-2:0];
            cnt_d = cnt_q + CNT_WIDTH'(1);
            if (cnt_q == CNT_WIDTH'(WR_WIDTH - 1)) begin
              cnt_d     = '0;
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = wr_word;
              if (ai_q) begin
                addr_d = addr_q + ADDR_WIDTH'(1);
              end else begin
                done_d = 1'b1;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end

    // Register file returns data the cycle after rd_en.
    if (load_q) begin
      tx_d = reg_port.rd_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mosi_sync_q  <= '0;
      state_q      <= IDLE;
      cnt_q        <= '0;
      cmd_q        <= '0;
      rx_q         <= '0;
      tx_q         <= '0;
      addr_q       <= '0;
      ai_q         <= 1'b0;
      done_q       <= 1'b0;
      miso_q       <= 1'b0;
      rd_en_q      <= 1'b0;
      load_q       <= 1'b0;
      rd_addr_q    <= '0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      mosi_sync_q  <= (mosi_sync_q << 1) | SYNC_STAGES'(mosi);
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      cmd_q        <= cmd_d;
      rx_q         <= rx_d;
      tx_q         <= tx_d;
      addr_q       <= addr_d;
      ai_q         <= ai_d;
      done_q       <= done_d;
      miso_q       <= miso_d;
      rd_en_q      <= rd_en_d;
      load_q       <= load_d;
      rd_addr_q    <= rd_addr_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign miso_oe    = busy & ~ss_level;
  assign miso       = miso_q;
  assign frame_done = frame_done_q;

  assign reg_port.rd_en   = rd_en_q;
  assign reg_port.rd_addr = rd_addr_q;
  assign reg_port.wr_en   = wr_en_q;
  assign reg_port.wr_addr = wr_addr_q;
  assign reg_port.wr_data = wr_data_q;

endmodule

// File: tb/tb_tdc_spi_responder.sv
// Bench for tdc_spi_responder: bit-banged SPI master, register-file responder and a
// frame-level reference model of the read/write traffic each frame should produce.
module tb_tdc_spi_responder;

  localparam int unsigned AW = 6;
  localparam int unsigned RDW = 24;
  localparam int unsigned WRW = 8;
  localparam int unsigned SS = 2;
  localparam int H = 6;  // SCLK half period in clk cycles

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sclk = 1'b0;
  logic ss_n = 1'b1;
  logic mosi = 1'b0;
  logic miso, miso_oe, frame_done, busy;

  tdc_spi_responder_if #(.ADDR_WIDTH(AW), .RD_WIDTH(RDW), .WR_WIDTH(WRW)) reg_if ();

  tdc_spi_responder #(
    .ADDR_WIDTH (AW),
    .RD_WIDTH   (RDW),
    .WR_WIDTH   (WRW),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sclk      (sclk),
    .ss_n      (ss_n),
    .mosi      (mosi),
    .miso      (miso),
    .miso_oe   (miso_oe),
    .frame_done(frame_done),
    .busy      (busy),
    .reg_port  (reg_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [23:0] regs [64];
  logic [5:0]  rd_log[$];
  logic [13:0] wr_log[$];
  int          fd_cnt = 0;
  logic        rd_pend = 1'b0;
  logic        rd_garbage = 1'b0;

  // Register file: data valid from the rd_en cycle through the following cycle, then junk.
  always @(negedge clk) begin
    if (rd_garbage) reg_if.rd_data = 24'($urandom);
    rd_garbage = rd_pend;
    rd_pend = 1'b0;
    if (reg_if.rd_en === 1'b1) begin
      reg_if.rd_data = regs[reg_if.rd_addr];
      rd_pend = 1'b1;
      rd_log.push_back(reg_if.rd_addr);
    end
    if (reg_if.wr_en === 1'b1) wr_log.push_back({reg_if.wr_addr, reg_if.wr_data});
    if (frame_done === 1'b1) fd_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bit(input logic b, output logic r);
    mosi = b;
    tick(H);
    sclk = 1'b1;
    r = miso;
    tick(H);
    sclk = 1'b0;
  endtask

  task automatic randomize_regs();
    for (int i = 0; i < 64; i++) regs[i] = 24'($urandom);
  endtask

  // Full frame: command byte plus ndata bits taken MSB-first from wbits[ndata-1:0].
  task automatic run_frame(input string name, input logic [7:0] cmd, input int ndata,
                           input logic [63:0] wbits);
    logic [63:0] rbits, exp_r;
    logic        r, ai, rw;
    logic [5:0]  base, a;
    logic [13:0] exp_w;
    int          cmd_miso_ones, nrd, nwr;
    rd_log.delete();
    wr_log.delete();
    fd_cnt = 0;
    rbits = '0;
    cmd_miso_ones = 0;
    ai = cmd[7];
    rw = cmd[6];
    base = cmd[5:0];

    ss_n = 1'b0;
    tick(H);
    for (int i = 7; i >= 0; i--) begin
      spi_bit(cmd[i], r);
      if (r !== 1'b0) cmd_miso_ones++;
    end
    for (int i = 0; i < ndata; i++) begin
      spi_bit(wbits[ndata-1-i], r);
      rbits[ndata-1-i] = r;
    end
    checks++;
    if (miso_oe !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL %s in_frame miso_oe=%b busy=%b want 1 1", name, miso_oe, busy);
    end
    tick(H);
    ss_n = 1'b1;
    tick(4 * H);

    exp_r = '0;
    if (!rw) begin
      for (int i = 0; i < ndata; i++) begin
        if (ai || i < 24) begin
          a = base + 6'(i / 24);
          exp_r[ndata-1-i] = regs[a][23-(i%24)];
        end
      end
    end
    nrd = rw ? 0 : 1 + (ai ? ndata / 24 : 0);
    nwr = rw ? (ai ? ndata / 8 : (ndata >= 8 ? 1 : 0)) : 0;

    checks++;
    if (cmd_miso_ones != 0) begin
      errors++;
      $display("FAIL %s cmd_miso got %0d ones want 0", name, cmd_miso_ones);
    end
    checks++;
    if (rbits !== exp_r) begin
      errors++;
      $display("FAIL %s miso_data got %h want %h", name, rbits, exp_r);
    end
    checks++;
    if (rd_log.size() != nrd) begin
      errors++;
      $display("FAIL %s rd_count got %0d want %0d", name, rd_log.size(), nrd);
    end else begin
      for (int k = 0; k < nrd; k++) begin
        checks++;
        if (rd_log[k] !== base + 6'(k)) begin
          errors++;
          $display("FAIL %s rd_addr[%0d] got %h want %h", name, k, rd_log[k], base + 6'(k));
        end
      end
    end
    checks++;
    if (wr_log.size() != nwr) begin
      errors++;
      $display("FAIL %s wr_count got %0d want %0d", name, wr_log.size(), nwr);
    end else begin
      for (int k = 0; k < nwr; k++) begin
        exp_w = {base + 6'(k), wbits[ndata-1-8*k -: 8]};
        checks++;
        if (wr_log[k] !== exp_w) begin
          errors++;
          $display("FAIL %s wr[%0d] addr/data got %h want %h", name, k, wr_log[k], exp_w);
        end
      end
    end
    checks++;
    if (fd_cnt != 1) begin
      errors++;
      $display("FAIL %s frame_done pulses got %0d want 1", name, fd_cnt);
    end
    checks++;
    if ({busy, miso_oe, miso} !== 3'b000) begin
      errors++;
      $display("FAIL %s after_frame busy/oe/miso got %b want 000", name, {busy, miso_oe, miso});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    sclk = 1'b0;
    ss_n = 1'b1;
    mosi = 1'b0;
    tick(3);
    checks++;
    if ({miso, miso_oe, reg_if.rd_en, reg_if.wr_en, frame_done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 000000",
               {miso, miso_oe, reg_if.rd_en, reg_if.wr_en, frame_done, busy});
    end
    checks++;
    if ({reg_if.rd_addr, reg_if.wr_addr, reg_if.wr_data} !== 20'h0) begin
      errors++;
      $display("FAIL reset_bus got %h want 0",
               {reg_if.rd_addr, reg_if.wr_addr, reg_if.wr_data});
    end
    rst_n = 1'b1;
    fd_cnt = 0;
    tick(10);
    checks++;
    if (fd_cnt != 0 || busy !== 1'b0 || miso_oe !== 1'b0) begin
      errors++;
      $display("FAIL post_reset fd=%0d busy=%b oe=%b want 0 0 0", fd_cnt, busy, miso_oe);
    end
  endtask

  task automatic test_read_single();
    randomize_regs();
    regs[6'h10] = 24'hA5C3F0;
    run_frame("read_single", 8'h10, 32, 64'($urandom));
  endtask

  task automatic test_write_single();
    run_frame("write_single", 8'h43, 24, {40'h0, 8'h5A, 16'($urandom)});
  endtask

  task automatic test_burst_read();
    randomize_regs();
    run_frame("burst_read_wrap", 8'hBF, 48, 64'($urandom));
  endtask

  task automatic test_burst_write();
    run_frame("burst_write_partial", 8'hC8, 20, {44'h0, 8'h11, 8'h22, 4'($urandom)});
  endtask

  task automatic test_abort();
    randomize_regs();
    run_frame("abort_read", 8'h05, 12, 64'($urandom));
    run_frame("after_abort", 8'h41, 8, 64'h9C);
  endtask

  task automatic test_random();
    logic [7:0] cmd;
    for (int n = 0; n < 8; n++) begin
      randomize_regs();
      cmd = 8'($urandom);
      run_frame("random", cmd, int'($urandom_range(0, 60)), {$urandom, $urandom});
    end
  endtask

  task automatic test_reset_mid_frame();
    logic       r;
    logic [7:0] cmd;
    cmd = 8'h43;
    ss_n = 1'b0;
    tick(H);
    for (int i = 7; i >= 0; i--) spi_bit(cmd[i], r);
    for (int i = 0; i < 4; i++) spi_bit(1'($urandom), r);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({miso, miso_oe, reg_if.rd_en, reg_if.wr_en, frame_done, busy} !== 6'b0) begin
      errors++;
      $display("FAIL midreset_ctrl got %b want 000000",
               {miso, miso_oe, reg_if.rd_en, reg_if.wr_en, frame_done, busy});
    end
    tick(3);
    rst_n = 1'b1;
    rd_log.delete();
    wr_log.delete();
    fd_cnt = 0;
    tick(2 * H);
    checks++;
    if ({reg_if.rd_addr, reg_if.wr_addr, reg_if.wr_data, busy, miso_oe} !== 22'h0) begin
      errors++;
      $display("FAIL midreset_release got %h want 0",
               {reg_if.rd_addr, reg_if.wr_addr, reg_if.wr_data, busy, miso_oe});
    end
    // Select still low: clocked bits must not start a frame.
    for (int i = 0; i < 16; i++) spi_bit(1'($urandom), r);
    tick(H);
    checks++;
    if (rd_log.size() != 0 || wr_log.size() != 0 || fd_cnt != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL stale_select rd=%0d wr=%0d fd=%0d busy=%b want 0 0 0 0",
               rd_log.size(), wr_log.size(), fd_cnt, busy);
    end
    ss_n = 1'b1;
    tick(2 * H);
    run_frame("after_reset", 8'h43, 8, 64'h5A);
  endtask

  initial begin
    test_reset();
    test_read_single();
    test_write_single();
    test_burst_read();
    test_burst_write();
    test_abort();
    test_reset_mid_frame();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
